button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Per-button conditioning front end between the raw board buttons (BTN3..BTN0) and the
//  ALARM_CLOCK setting/stopwatch/timer modules. Each channel: 2-FF synchroniser, counter
//  debounce, one-cycle press pulse, and optional hold-to-auto-repeat. Repeat is enabled
//  per channel by mask; the default mask enables it on increase/decrease only.
//  Consumers use btn_press as a single-cycle strobe and btn_level as a clean held level.
// PARAMETERS
//  N_BTN          4           number of button channels (bit0=decrease, 1=increase, 2=right, 3=left)
//  DEBOUNCE_CYC   1_000_000   cycles the synchronised input must stay stable (20 ms @ 50 MHz)
//  REPEAT_DELAY   25_000_000  cycles held after the press pulse before the first repeat (500 ms)
//  REPEAT_PERIOD  5_000_000   cycles between subsequent repeat pulses (100 ms)
//  REPEAT_MASK    4'b0011     1 = auto-repeat enabled on that channel
// PORTS
//  clk        in   1      50 MHz system clock
//  rst_n      in   1      asynchronous active-low reset
//  btn_raw    in   N_BTN  raw, asynchronous, active-high button inputs
//  btn_level  out  N_BTN  debounced level, registered
//  btn_press  out  N_BTN  one-cycle pulse on debounced press and on each auto-repeat
//  btn_rel    out  N_BTN  one-cycle pulse on debounced release
// BEHAVIOUR
//  Reset: one clock; reset asynchronous, active-low. While rst_n=0, all sync FFs, counters,
//   FSMs and all outputs are 0; channels start IDLE. Deassertion is taken synchronously:
//   the first active edge is the first clk rise with rst_n=1.
//  Sync: s1<=btn_raw, s2<=s1. Only s2 is used downstream.
//  Debounce, per channel: while s2 != btn_level, db_cnt increments each cycle; when
//   s2==btn_level, db_cnt <= 0. On a cycle with s2 != btn_level and db_cnt == DEBOUNCE_CYC-1,
//   btn_level <= s2 and db_cnt <= 0. Width is clog2(DEBOUNCE_CYC); the counter never wraps.
//  Latency: a clean raw rise at edge k gives btn_level=1 and btn_press=1 after edge
//   k+1+DEBOUNCE_CYC. A glitch shorter than DEBOUNCE_CYC cycles produces no output change.
//  btn_press and btn_rel are registered and asserted in the same cycle that btn_level
//   rises or falls. They are never asserted together on one channel.
//  Repeat FSM per channel, rp_cnt width clog2(max(REPEAT_DELAY,REPEAT_PERIOD)):
//   IDLE   : on level rise -> press pulse; if mask bit set -> DELAY, rp_cnt<=0; else -> HELD.
//   HELD   : stay until level falls -> IDLE.
//   DELAY  : rp_cnt++; at rp_cnt==REPEAT_DELAY-1 -> pulse, rp_cnt<=0, -> REPEAT.
//   REPEAT : rp_cnt++; at rp_cnt==REPEAT_PERIOD-1 -> pulse, rp_cnt<=0, stay.
//   Any state, level falls -> IDLE, rp_cnt<=0, btn_rel pulse; release wins over a repeat due that cycle.
//  Channels are fully independent. Simultaneous presses each produce their own pulses in
//   the same cycle; no priority or lockout between channels.
//  Reset mid-hold: outputs drop to 0 at once. If the button is still held after reset
//   release, a fresh press pulse follows after the normal debounce latency.
//  Input held at reset release counts as a new press.
// TESTING (bench params: DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  1 Reset: rst_n=0 mid-simulation with btn_raw=4'hF -> all outputs 0 within the same
//    timestep, no clk edge needed.
//  2 Clean press ch2: raw rises at edge k and is held -> btn_level[2] and one press
//    pulse at edge k+5; btn_press[2] stays 0 afterwards (mask bit 0).
//  3 Bounce ch3: raw toggled 1,0,1,0 every 2 cycles, then held high -> exactly one press
//    pulse, 5 cycles after the final stable rise; no btn_rel.
//  4 Auto-repeat ch1 held 30 cycles past the press -> pulses at press+0, +10, +13, +16, ...;
//    on release, one btn_rel pulse, no further press pulses.
//  5 Release colliding with repeat: level falls in the cycle a repeat is due -> btn_rel=1,
//    btn_press=0 that cycle; FSM in IDLE.
//  6 Simultaneous ch0+ch1 press -> both press bits high in the same cycle. Reset asserted
//    during REPEAT with the button still held -> new press pulse 6 cycles after rst_n rise.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: per-button synchroniser, debounce, press/release pulses and hold-to-repeat
module button_conditioner #(
    parameter int N_BTN = 4,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter logic [N_BTN-1:0] REPEAT_MASK = 'b0011
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_rel
);
    localparam int DBW = DEBOUNCE_CYC > 1 ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int RPM = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPW = RPM > 1 ? $clog2(RPM) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYC - 1);
    localparam logic [RPW-1:0] RD_LAST = RPW'(REPEAT_DELAY - 1);
    localparam logic [RPW-1:0] RP_LAST = RPW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, HELD, DELAY, RPT} state_t;

    logic [N_BTN-1:0] s1, s2;

    // two-flop synchroniser for the asynchronous button inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [DBW-1:0] db_cnt;
        logic [RPW-1:0] rp_cnt;
        state_t st;
        logic lvl, prs, rls, flip;

        assign flip = (s2[i] != lvl) && (db_cnt == DB_LAST);
        assign btn_level[i] = lvl;
        assign btn_press[i] = prs;
        assign btn_rel[i] = rls;

        // debounce counter, level/pulse registers and repeat FSM; a release overrides any due repeat
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt <= '0;
                rp_cnt <= '0;
                st <= IDLE;
                lvl <= 1'b0;
                prs <= 1'b0;
                rls <= 1'b0;
            end else begin
                db_cnt <= (s2[i] == lvl || flip) ? '0 : db_cnt + DBW'(1);
                if (flip) lvl <= s2[i];
                prs <= 1'b0;
                rls <= 1'b0;
                if (flip && !s2[i]) begin
                    st <= IDLE;
                    rp_cnt <= '0;
                    rls <= 1'b1;
                end else begin
                    case (st)
                        IDLE: if (flip) begin
                            prs <= 1'b1;
                            rp_cnt <= '0;
                            st <= REPEAT_MASK[i] ? DELAY : HELD;
                        end
                        DELAY: if (rp_cnt == RD_LAST) begin
                            prs <= 1'b1;
                            rp_cnt <= '0;
                            st <= RPT;
                        end else rp_cnt <= rp_cnt + RPW'(1);
                        RPT: if (rp_cnt == RP_LAST) begin
                            prs <= 1'b1;
                            rp_cnt <= '0;
                        end else rp_cnt <= rp_cnt + RPW'(1);
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and randomized checks against a behavioural model
module tb_button_conditioner;
    localparam int D = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam logic [3:0] MASK = 4'b0011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] btn_raw = '0;
    logic [3:0] btn_level, btn_press, btn_rel;

    int chk_cnt = 0;
    int pass_cnt = 0;

    logic [3:0] m_s1, m_s2, m_lvl, m_prs, m_rel;
    int run[4];
    int age[4];

    button_conditioner #(
        .N_BTN(4), .DEBOUNCE_CYC(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_rel(btn_rel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: level follows the synchronised input once it has disagreed for D edges in a row;
    // a held masked button repeats at ages RD, RD+RP, RD+2RP, ... edges after its press.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0;
            for (int c = 0; c < 4; c++) begin
                run[c] = 0;
                age[c] = 0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                m_prs[c] = 1'b0;
                m_rel[c] = 1'b0;
                run[c] = (m_s2[c] != m_lvl[c]) ? run[c] + 1 : 0;
                if (run[c] == D) begin
                    run[c] = 0;
                    m_lvl[c] = m_s2[c];
                    if (m_lvl[c]) begin
                        m_prs[c] = 1'b1;
                        age[c] = 0;
                    end else m_rel[c] = 1'b1;
                end else if (m_lvl[c] && MASK[c]) begin
                    age[c]++;
                    if (age[c] == RD || (age[c] > RD && (age[c] - RD) % RP == 0)) m_prs[c] = 1'b1;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        check("level", btn_level, m_lvl);
        check("press", btn_press, m_prs);
        check("rel", btn_rel, m_rel);
    end

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(3);
        btn_raw = 4'hF;
        tick(8);
        check("all_held_level", btn_level, 4'hF);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_level", btn_level, 4'h0);
        check("async_rst_press", btn_press, 4'h0);
        check("async_rst_rel", btn_rel, 4'h0);
        tick(1);
        btn_raw = 4'h0;
        tick(1);
        rst_n = 1'b1;
        tick(10);

        btn_raw[2] = 1'b1;
        tick(5);
        check("ch2_early_press", btn_press[2], 1'b0);
        tick(1);
        check("ch2_press", btn_press[2], 1'b1);
        check("ch2_level", btn_level[2], 1'b1);
        tick(1);
        check("ch2_press_once", btn_press[2], 1'b0);
        tick(20);
        check("ch2_no_repeat", btn_press[2], 1'b0);
        btn_raw[2] = 1'b0;
        tick(6);
        check("ch2_rel", btn_rel[2], 1'b1);
        tick(4);

        for (int k = 0; k < 4; k++) begin
            btn_raw[3] = ~btn_raw[3];
            tick(2);
        end
        check("ch3_bounce_level", btn_level[3], 1'b0);
        btn_raw[3] = 1'b1;
        tick(5);
        check("ch3_early_press", btn_press[3], 1'b0);
        tick(1);
        check("ch3_press", btn_press[3], 1'b1);
        check("ch3_no_rel", btn_rel[3], 1'b0);
        btn_raw[3] = 1'b0;
        tick(10);

        btn_raw[1] = 1'b1;
        tick(6);
        check("ch1_press", btn_press[1], 1'b1);
        for (int j = 1; j <= 30; j++) begin
            tick(1);
            check("ch1_repeat", btn_press[1], 1'(j inside {10, 13, 16, 19, 22, 25, 28}));
        end
        btn_raw[1] = 1'b0;
        tick(5);
        check("ch1_rel_early", btn_rel[1], 1'b0);
        tick(1);
        check("ch1_rel", btn_rel[1], 1'b1);
        check("ch1_rel_nopress", btn_press[1], 1'b0);
        tick(10);

        btn_raw[1] = 1'b1;
        tick(6);
        check("coll_press", btn_press[1], 1'b1);
        tick(10);
        check("coll_first_repeat", btn_press[1], 1'b1);
        btn_raw[1] = 1'b0;
        tick(6);
        check("coll_rel", btn_rel[1], 1'b1);
        check("coll_press_suppressed", btn_press[1], 1'b0);
        tick(1);
        check("coll_level_low", btn_level[1], 1'b0);
        tick(5);

        btn_raw = 4'b0011;
        tick(6);
        check("simul_press", btn_press, 4'b0011);
        tick(14);
        #2 rst_n = 1'b0;
        #1;
        check("rpt_rst_level", btn_level, 4'h0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("post_rst_early", btn_press, 4'h0);
        tick(1);
        check("post_rst_press", btn_press, 4'b0011);
        tick(3);
        btn_raw = 4'h0;
        tick(10);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 99) < 3) btn_raw[b] = ~btn_raw[b];
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                tick($urandom_range(1, 3));
                rst_n = 1'b1;
            end
        end
        tick(2);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
